// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional parity state is enabled by UART_TX_PARITY_EN.
package uart_pkg;

    localparam int OVERSAMPLE      = 16;
    localparam int DEFAULT_DBIT    = 8;
    localparam int DEFAULT_SB_TICK = 16;
    localparam int DEFAULT_DVSR_W  = 11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one s_tick every dvsr+1 cycles, restartable via clr.
// Latency: s_tick is combinational from the counter; clr takes effect on the next edge.
// Backpressure: none; a lowered dvsr fires at once through the >= compare.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DVSR_W = DEFAULT_DVSR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic [DVSR_W-1:0] dvsr,
    output logic              s_tick
);

    logic [DVSR_W-1:0] cnt;

    // Using >= rather than == keeps a mid-count decrease of dvsr from overshooting.
    assign s_tick = (cnt >= dvsr);

    // Free-running divisor counter, held at zero while clr is asserted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr || s_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that pops words from a TX FIFO and serialises start/data/(parity)/stop.
// Latency: tx falls on the edge ending the fifo_rd cycle; frames are separated by 1 idle cycle.
// Backpressure: pops only when idle and fifo_empty=0; parity bit present with UART_TX_PARITY_EN.
module uart_tx_fifo_drain
    import uart_pkg::*;
#(
    parameter int DBIT    = DEFAULT_DBIT,
    parameter int SB_TICK = DEFAULT_SB_TICK,
    parameter int DVSR_W  = DEFAULT_DVSR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic              fifo_empty,
    input  logic [DBIT-1:0]   fifo_rdata,
    output logic              fifo_rd,
    output logic              tx,
    output logic              busy,
    output logic              tx_done_tick
);

    localparam int S_W = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST      = N_W'(DBIT - 1);

    uart_tx_state_t  state_q, state_d;
    logic [S_W-1:0]  s_q, s_d;
    logic [N_W-1:0]  n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            tx_q, tx_d;
    logic            pop;
    logic            done;
    logic            s_tick;
`ifdef UART_TX_PARITY_EN
    logic            par_q, par_d;
`endif

    // Baud counter sits at zero while idle so every frame starts phase-aligned.
    uart_baud_gen #(
        .DVSR_W (DVSR_W)
    ) u_baud_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state_q == IDLE),
        .dvsr    (dvsr),
        .s_tick  (s_tick)
    );

    // Frame state, counters, shift register and the registered line level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic; tx_d carries the level of the state being entered.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        done    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    b_d     = fifo_rdata;
                    s_d     = '0;
                    n_d     = '0;
                    tx_d    = 1'b0;
                    state_d = START;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^fifo_rdata;
`endif
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d     = '0;
                        tx_d    = b_q[0];
                        state_d = DATA;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                            tx_d    = par_q;
                            state_d = PARITY;
`else
                            tx_d    = 1'b1;
                            state_d = STOP;
`endif
                        end else begin
                            n_d  = n_q + 1'b1;
                            tx_d = b_d[0];
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d     = '0;
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP_LAST) begin
                        done    = 1'b1;
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign fifo_rd      = pop & reset_n;
    assign tx           = tx_q;
    assign busy         = (state_q != IDLE);
    assign tx_done_tick = done;

endmodule
